mem_port_arbiter: RTL and testbench

Shares the single external memory port, which uses the req/addr_ok/data_ok protocol, between the IF stage (instruction fetch) and the EX/MEM stage (data load/store). Arbitrates at most one address handshake per cycle with fixed data priority plus a starvation guard. Tracks outstanding requests in order so each in-order `data_ok`/`rdata` is routed back to the requester that issued it. Sits between the pipeline stages and the memory bridge.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_resp_order_fifo.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: source IDs, access sizes
// and bus widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Source IDs as stored in the response-order FIFO.
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Access size encodings carried on *_size / mem_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/mem_port_arbiter_resp_order_fifo.sv
// resp_order_fifo: 1-bit-wide synchronous FIFO recording which source owns
// each accepted-but-unanswered request, oldest at the head.
module resp_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] slot_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents only matter between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) slot_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/addr_ok/data_ok memory port between the
// instruction-fetch and data stages and routes in-order responses back.
//
// Handshake: a source raises *_req with stable fields and keeps them until
// its *_addr_ok pulse; the request is accepted in that cycle. Every accepted
// request (read or write) later gets exactly one *_data_ok, in acceptance
// order, no earlier than the cycle after its addr_ok. Downstream follows the
// same rules with mem_req/mem_addr_ok/mem_data_ok.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                hold_valid_q, hold_valid_d;
  logic                hold_src_q, hold_src_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic grant_src;
  logic granted_req;
  logic handshake;
  logic resp_pop;
  logic fifo_head, fifo_full, fifo_empty;

  // Grant: a stalled request keeps the port; otherwise data wins unless
  // the instruction side has already waited through STARVE_LIMIT data grants.
  always_comb begin
    grant_src = SRC_INST;
    if (hold_valid_q)
      grant_src = hold_src_q;
    else if (inst_req && data_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT)))
      grant_src = SRC_INST;
    else if (data_req)
      grant_src = SRC_DATA;
  end

  // Drive the downstream request from the granted source.
  always_comb begin
    granted_req = inst_req;
    mem_wr      = inst_wr;
    mem_size    = inst_size;
    mem_wstrb   = inst_wstrb;
    mem_addr    = inst_addr;
    mem_wdata   = inst_wdata;
    if (grant_src == SRC_DATA) begin
      granted_req = data_req;
      mem_wr      = data_wr;
      mem_size    = data_size;
      mem_wstrb   = data_wstrb;
      mem_addr    = data_addr;
      mem_wdata   = data_wdata;
    end
  end

  // Full is the pre-pop occupancy, so a same-cycle response cannot free a slot
  // for a new request.
  assign mem_req      = granted_req && !fifo_full && !reset;
  assign handshake    = mem_req && mem_addr_ok;
  assign inst_addr_ok = handshake && (grant_src == SRC_INST);
  assign data_addr_ok = handshake && (grant_src == SRC_DATA);

  // Responses with nothing outstanding are dropped.
  assign resp_pop     = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = resp_pop && (fifo_head == SRC_INST);
  assign data_data_ok = resp_pop && (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Hold and starvation next-state: a presented but unaccepted request pins
  // the grant; the starvation count tracks data grants an instruction waits on.
  always_comb begin
    hold_valid_d = mem_req && !mem_addr_ok;
    hold_src_d   = hold_valid_d ? grant_src : hold_src_q;
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || (handshake && (grant_src == SRC_INST)))
      starve_cnt_d = '0;
    else if (handshake && (grant_src == SRC_DATA) &&
             (starve_cnt_q != STARVE_W'(STARVE_LIMIT)))
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_src_q   <= SRC_INST;
      starve_cnt_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_src_q   <= hold_src_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  resp_order_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (handshake),
    .din_i  (grant_src),
    .pop_i  (resp_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a randomized
// phase with a behavioural memory model; responses are checked by a monitor
// against per-source expected queues.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk, reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fail;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] mem_pend_q[$];

  // random-phase model state
  bit          stall_prev;
  logic [31:0] stall_addr;
  int          wait_cnt;
  logic [15:0] inst_seq, data_seq;

  mem_port_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_wstrb  (inst_wstrb),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [1:0] size_of(input logic [31:0] a);
    return a[9] ? 2'd2 : {1'b0, a[10]};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_wstrb = 4'd0;
    inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
  endtask

  // Request fields are derived from the address so the memory side can tell
  // whether the right source's fields reached mem_*.
  task automatic set_inst(input logic [31:0] a);
    inst_req = 1'b1; inst_addr = a; inst_wr = a[8];
    inst_size = size_of(a); inst_wstrb = a[7:4]; inst_wdata = ~a;
  endtask

  task automatic set_data(input logic [31:0] a);
    data_req = 1'b1; data_addr = a; data_wr = a[8];
    data_size = size_of(a); data_wstrb = a[7:4]; data_wdata = ~a;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (inst_data_ok && data_data_ok) begin
          n_checks++; n_fail++;
          $display("FAIL both_data_ok: inst and data responses in one cycle at %0t", $time);
        end
        if (inst_data_ok) begin
          if (exp_inst_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL inst_data_ok: got response %h expected none at %0t", inst_rdata, $time);
          end else
            chk32("inst_rdata", inst_rdata, exp_inst_q.pop_front());
        end
        if (data_data_ok) begin
          if (exp_data_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL data_data_ok: got response %h expected none at %0t", data_rdata, $time);
          end else
            chk32("data_rdata", data_rdata, exp_data_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- random-phase cycle: requesters + memory model ----------------
  task automatic rand_cycle(input bit issue_en);
    bit          ia, da, is_inst;
    logic [31:0] a;
    logic [7:0]  r8;
    smp();
    ia = inst_addr_ok;
    da = data_addr_ok;
    if (stall_prev) begin
      chk1("hold_mem_req", mem_req, 1'b1);
      chk32("hold_mem_addr", mem_addr, stall_addr);
    end
    if (mem_req && mem_addr_ok) begin
      is_inst = (mem_addr[31:24] == 8'h1C);
      chk1("src_inst_addr_ok", ia, is_inst);
      chk1("src_data_addr_ok", da, !is_inst);
      chk32("mem_wdata", mem_wdata, ~mem_addr);
      chk32("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
            {25'd0, mem_addr[8], size_of(mem_addr), mem_addr[7:4]});
      mem_pend_q.push_back(mem_addr);
    end else begin
      chk1("idle_inst_addr_ok", ia, 1'b0);
      chk1("idle_data_addr_ok", da, 1'b0);
    end
    stall_prev = mem_req && !mem_addr_ok;
    stall_addr = mem_addr;
    // an instruction request may wait through at most 4 data grants
    if (!inst_req || ia) wait_cnt = 0;
    else if (da) begin
      wait_cnt++;
      chk1("starve_bound", (wait_cnt <= 4), 1'b1);
    end
    cyc();
    if (ia) inst_req = 1'b0;
    if (da) data_req = 1'b0;
    if (issue_en && !inst_req && ($urandom_range(0, 2) != 0)) begin
      inst_seq++;
      r8 = 8'($urandom_range(0, 255));
      a  = {8'h1C, r8, inst_seq};
      set_inst(a);
      exp_inst_q.push_back(rdata_of(a));
    end
    if (issue_en && !data_req && ($urandom_range(0, 2) != 0)) begin
      data_seq++;
      r8 = 8'($urandom_range(0, 255));
      a  = {8'h80, r8, data_seq};
      set_data(a);
      exp_data_q.push_back(rdata_of(a));
    end
    mem_addr_ok = ($urandom_range(0, 3) != 0);
    if (mem_pend_q.size() > 0 && ($urandom_range(0, 1) == 1)) begin
      mem_data_ok = 1'b1;
      mem_rdata   = rdata_of(mem_pend_q.pop_front());
    end else if (mem_pend_q.size() == 0 && ($urandom_range(0, 7) == 0)) begin
      mem_data_ok = 1'b1;              // spurious: nothing outstanding
      mem_rdata   = $urandom;
    end else begin
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit is_inst;
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    reset = 1'b1;
    // drive activity during reset: nothing may leak out
    inst_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    fork
      monitor_loop();
    join_none

    smp();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", data_data_ok, 1'b0);
    cyc();
    idle_inputs();
    reset = 1'b0;
    cyc();

    // ---- single read ----
    set_inst(32'h1C00_0000);
    mem_addr_ok = 1'b1;
    exp_inst_q.push_back(32'h1C00_0000);
    smp();
    chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk1("t1_data_addr_ok", data_addr_ok, 1'b0);
    chk32("t1_mem_addr", mem_addr, 32'h1C00_0000);
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h1C00_0000;
    smp();
    chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk1("t1_data_data_ok", data_data_ok, 1'b0);
    cyc();
    mem_data_ok = 1'b0;
    cyc();

    // ---- contention with stall: data wins and keeps the port ----
    set_inst(32'h1C00_1000);
    set_data(32'h8000_2000);
    exp_data_q.push_back(32'h0000_00D1);
    exp_inst_q.push_back(32'h0000_00E1);
    for (int k = 0; k < 4; k++) begin
      mem_addr_ok = (k == 3);
      smp();
      chk32("t2_mem_addr", mem_addr, 32'h8000_2000);
      chk1("t2_data_addr_ok", data_addr_ok, (k == 3));
      chk1("t2_inst_addr_ok", inst_addr_ok, 1'b0);
      cyc();
    end
    data_req = 1'b0;
    smp();
    chk32("t2_inst_mem_addr", mem_addr, 32'h1C00_1000);
    chk1("t2_inst_addr_ok_next", inst_addr_ok, 1'b1);
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_00D1;
    smp();
    chk1("t2_data_data_ok", data_data_ok, 1'b1);
    cyc();
    mem_rdata = 32'h0000_00E1;
    smp();
    chk1("t2_inst_data_ok", inst_data_ok, 1'b1);
    cyc();
    mem_data_ok = 1'b0;
    cyc();

    // ---- a stalled inst request is not pre-empted by a later data request ----
    set_inst(32'h1C00_2200);
    mem_addr_ok = 1'b0;
    exp_inst_q.push_back(32'h0000_00F1);
    exp_data_q.push_back(32'h0000_00F2);
    smp();
    chk32("t2b_mem_addr0", mem_addr, 32'h1C00_2200);
    cyc();
    set_data(32'h8000_2200);
    smp();
    chk32("t2b_mem_addr1", mem_addr, 32'h1C00_2200);
    chk1("t2b_data_addr_ok1", data_addr_ok, 1'b0);
    cyc();
    mem_addr_ok = 1'b1;
    smp();
    chk1("t2b_inst_addr_ok", inst_addr_ok, 1'b1);
    chk1("t2b_data_addr_ok2", data_addr_ok, 1'b0);
    cyc();
    inst_req = 1'b0;
    smp();
    chk1("t2b_data_addr_ok3", data_addr_ok, 1'b1);
    cyc();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_00F1;
    cyc();
    mem_rdata = 32'h0000_00F2;
    cyc();
    mem_data_ok = 1'b0;
    cyc();

    // ---- starvation guard: 4 data grants then 1 inst grant ----
    set_inst(32'h1C00_3000);
    set_data(32'h8000_3000);
    mem_addr_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      is_inst = ((k % 5) == 4);
      if (is_inst) exp_inst_q.push_back(32'h100 + k);
      else         exp_data_q.push_back(32'h100 + k);
      if (k > 0) begin
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h100 + (k - 1);
      end
      smp();
      chk1("t3_inst_grant", inst_addr_ok, is_inst);
      chk1("t3_data_grant", data_addr_ok, !is_inst);
      cyc();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h100 + 9;
    cyc();
    mem_data_ok = 1'b0;
    cyc();

    // ---- order tracking and FIFO full ----
    mem_addr_ok = 1'b1;
    set_inst(32'h1C00_4000);
    exp_inst_q.push_back(32'hA);
    smp(); chk1("t4_addr_ok0", inst_addr_ok, 1'b1); cyc();
    inst_req = 1'b0;
    set_data(32'h8000_4000);
    exp_data_q.push_back(32'hB);
    smp(); chk1("t4_addr_ok1", data_addr_ok, 1'b1); cyc();
    set_data(32'h8000_4100);
    exp_data_q.push_back(32'hC);
    smp(); chk1("t4_addr_ok2", data_addr_ok, 1'b1); cyc();
    data_req = 1'b0;
    set_inst(32'h1C00_4100);
    exp_inst_q.push_back(32'hD);
    smp(); chk1("t4_addr_ok3", inst_addr_ok, 1'b1); cyc();
    set_inst(32'h1C00_4200);
    exp_inst_q.push_back(32'hE);
    smp();
    chk1("t4_full_mem_req", mem_req, 1'b0);
    chk1("t4_full_addr_ok", inst_addr_ok, 1'b0);
    cyc();
    mem_data_ok = 1'b1; mem_rdata = 32'hA;
    smp();
    chk1("t4_full_pop_mem_req", mem_req, 1'b0);
    chk1("t4_full_pop_addr_ok", inst_addr_ok, 1'b0);
    chk1("t4_resp_a", inst_data_ok, 1'b1);
    cyc();
    mem_rdata = 32'hB;
    smp();
    chk1("t4_fifth_addr_ok", inst_addr_ok, 1'b1);
    chk1("t4_resp_b", data_data_ok, 1'b1);
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_rdata = 32'hC;
    smp(); chk1("t4_resp_c", data_data_ok, 1'b1); cyc();
    mem_rdata = 32'hD;
    smp(); chk1("t4_resp_d", inst_data_ok, 1'b1); cyc();
    mem_rdata = 32'hE;
    smp(); chk1("t4_resp_e", inst_data_ok, 1'b1); cyc();
    mem_data_ok = 1'b0;
    cyc();

    // ---- spurious response, then async reset with requests outstanding ----
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk1("t5_spur_inst", inst_data_ok, 1'b0);
    chk1("t5_spur_data", data_data_ok, 1'b0);
    cyc();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    set_inst(32'h1C00_5000);
    exp_inst_q.push_back(32'h5);
    smp(); chk1("t5_out0", inst_addr_ok, 1'b1); cyc();
    inst_req = 1'b0;
    set_data(32'h8000_5000);
    exp_data_q.push_back(32'h6);
    smp(); chk1("t5_out1", data_addr_ok, 1'b1); cyc();
    data_req = 1'b0;
    set_inst(32'h1C00_5100);
    mem_addr_ok = 1'b0;
    smp();
    chk1("t5_pre_rst_mem_req", mem_req, 1'b1);
    #2;
    reset = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h5;
    #1;
    chk1("t5_rst_mem_req", mem_req, 1'b0);
    chk1("t5_rst_addr_ok", inst_addr_ok, 1'b0);
    chk1("t5_rst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("t5_rst_data_data_ok", data_data_ok, 1'b0);
    exp_inst_q.delete();
    exp_data_q.delete();
    cyc();
    reset = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h1234;
    smp();
    chk1("t5_post_rst_inst_dok", inst_data_ok, 1'b0);
    chk1("t5_post_rst_data_dok", data_data_ok, 1'b0);
    cyc();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    set_inst(32'h1C00_6000);
    exp_inst_q.push_back(32'h6000_0001);
    smp(); chk1("t5_new_addr_ok", inst_addr_ok, 1'b1); cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h6000_0001;
    smp(); chk1("t5_new_data_ok", inst_data_ok, 1'b1); cyc();
    mem_data_ok = 1'b0;
    cyc();
    chk32("dir_inst_q_empty", 32'(exp_inst_q.size()), 32'd0);
    chk32("dir_data_q_empty", 32'(exp_data_q.size()), 32'd0);

    // ---- randomized traffic ----
    stall_prev = 1'b0;
    wait_cnt   = 0;
    inst_seq   = 16'd0;
    data_seq   = 16'd0;
    for (int c = 0; c < 600; c++) rand_cycle(1'b1);
    // drain with a bounded cycle budget
    for (int c = 0; c < 300; c++) begin
      if (!inst_req && !data_req && mem_pend_q.size() == 0 &&
          exp_inst_q.size() == 0 && exp_data_q.size() == 0) break;
      rand_cycle(1'b0);
    end
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    cyc();
    cyc();
    chk32("drain_inst_q", 32'(exp_inst_q.size()), 32'd0);
    chk32("drain_data_q", 32'(exp_data_q.size()), 32'd0);
    chk32("drain_mem_q", 32'(mem_pend_q.size()), 32'd0);
    chk1("drain_inst_req", inst_req, 1'b0);
    chk1("drain_data_req", data_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
